// File: rtl/accel_pkg.sv
// Shared constants for the accelerator cores and their ROM arbiters.
// Holds the rom_Occ geometry, the core count and the arbiter FSM encoding.
package accel_pkg;

  localparam int OCC_ADDR_W = 8;
  localparam int OCC_DATA_W = 32;
  localparam int N_CORE     = 2;

  localparam logic [0:0] ARB_S  = 1'b0;
  localparam logic [0:0] LOCK_S = 1'b1;

endpackage

// File: rtl/occ_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, cyclic.
// Generic so it can also front the rom_C port.
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

  logic             found;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int off = 0; off < N; off++) begin
      // ptr is always < N, so a single subtraction is enough to wrap
      sum = {1'b0, ptr} + (IDX_W+1)'(off);
      if (sum >= (IDX_W+1)'(N)) begin
        sum = sum - (IDX_W+1)'(N);
      end
      cand = sum[IDX_W-1:0];
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/occ_rom_arbiter.sv
// Shares the single rom_Occ read port between N_REQ search cores with
// round-robin arbitration, optional short locking and tagged read return.
module occ_rom_arbiter
  import accel_pkg::*;
#(
  parameter int N_REQ    = N_CORE,
  parameter int ADDR_W   = OCC_ADDR_W,
  parameter int DATA_W   = OCC_DATA_W,
  parameter int ROM_LAT  = 1,
  parameter int MAX_LOCK = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ-1:0]        lock_i,
  input  logic [N_REQ*ADDR_W-1:0] addr_i,
  output logic [N_REQ-1:0]        gnt_o,
  output logic [N_REQ-1:0]        rvalid_o,
  output logic [DATA_W-1:0]       rdata_o,
  output logic                    ce_rom_Occ_o,
  output logic [ADDR_W-1:0]       addr_rom_Occ_o,
  input  logic [DATA_W-1:0]       data_rom_Occ_i
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  logic [0:0]       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner;
  logic [CNT_W-1:0] lock_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             idle_seen;

  logic [N_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] rr_next;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] win_idx;
  logic             any_gnt;

  logic             tag_vld [ROM_LAT];
  logic [IDX_W-1:0] tag_idx [ROM_LAT];
  logic [N_REQ-1:0] rvalid_next;

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req (req_i),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // Grant is combinational and masked by reset so nothing leaks to the ROM while held
  always_comb begin
    gnt     = '0;
    win_idx = '0;
    if (rst_n) begin
      if (state == ARB_S) begin
        gnt     = pick_gnt;
        win_idx = pick_idx;
      end else if (req_i[owner]) begin
        gnt[owner] = 1'b1;
        win_idx    = owner;
      end
    end
  end

  assign any_gnt      = |gnt;
  assign gnt_o        = gnt;
  assign ce_rom_Occ_o = any_gnt;

  always_comb begin
    addr_rom_Occ_o = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt[k]) begin
        addr_rom_Occ_o = addr_i[k*ADDR_W +: ADDR_W];
      end
    end
  end

  assign rr_next  = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
  assign cnt_next = (lock_cnt < CNT_W'(MAX_LOCK)) ? lock_cnt + CNT_W'(1) : lock_cnt;

  // rr_ptr only moves on ARB grants, so after a lock it still points past the owner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_S;
      rr_ptr    <= '0;
      owner     <= '0;
      lock_cnt  <= '0;
      idle_seen <= 1'b0;
    end else begin
      case (state)
        ARB_S: begin
          if (any_gnt) begin
            rr_ptr <= rr_next;
            if (lock_i[pick_idx]) begin
              state     <= LOCK_S;
              owner     <= pick_idx;
              lock_cnt  <= CNT_W'(1);
              idle_seen <= 1'b0;
            end
          end
        end
        default: begin
          if (!lock_i[owner]) begin
            state     <= ARB_S;
            lock_cnt  <= '0;
            idle_seen <= 1'b0;
          end else if (req_i[owner]) begin
            idle_seen <= 1'b0;
            if (cnt_next >= CNT_W'(MAX_LOCK)) begin
              state    <= ARB_S;
              lock_cnt <= '0;
            end else begin
              lock_cnt <= cnt_next;
            end
          end else if (idle_seen) begin
            state     <= ARB_S;
            lock_cnt  <= '0;
            idle_seen <= 1'b0;
          end else begin
            idle_seen <= 1'b1;
          end
        end
      endcase
    end
  end

  // Tag pipe: the output register is the last stage, so ROM_LAT+1 stages in total
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROM_LAT; i++) begin
        tag_vld[i] <= 1'b0;
        tag_idx[i] <= '0;
      end
    end else begin
      tag_vld[0] <= any_gnt;
      tag_idx[0] <= win_idx;
      for (int i = 1; i < ROM_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end
    end
  end

  always_comb begin
    rvalid_next = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (tag_vld[ROM_LAT-1] && (tag_idx[ROM_LAT-1] == IDX_W'(k))) begin
        rvalid_next[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_o <= '0;
      rdata_o  <= '0;
    end else begin
      rvalid_o <= rvalid_next;
      if (tag_vld[ROM_LAT-1]) begin
        rdata_o <= data_rom_Occ_i;
      end
    end
  end

endmodule
